// File: rtl/uart_rx_pkg.sv
// Shared UART definitions (state encoding, frame width, default baud divisor).
// UART_RX_PARITY_EN adds the PARITY state to the encoding.
package npu_uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } uart_state_e;

  // Even parity: parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, byte/status pulses out.
// UART_RX_PARITY_EN adds parity_err.
interface uart_rx_if;
  import npu_uart_pkg::*;

  logic                 rx_serial;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  modport slave (
    input  rx_serial,
    output rx_data,
    output rx_valid,
    output frame_err,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output busy
  );

  modport master (
    output rx_serial,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    input  busy
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, LSB first, one stop bit, mid-bit sampling.
// UART_RX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_rx
  import npu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 pbad_q, pbad_d;
  logic                 perr_q, perr_d;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx.rx_serial),
    .q   (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Re-check the line mid-start-bit to reject glitches.
        if (cnt_q == MID) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx_q == 3'd7) state_d = PARITY;
`else
          if (idx_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          pbad_d  = even_parity(shift_q) ^ rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end else begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (pbad_q) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end
        end
      end
      WAIT_IDLE: begin
        // Hold here through a break so it yields a single frame_err.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= pbad_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx at CLKS_PER_BIT=16 against a frame-level model.
// Define UART_RX_PARITY_EN for the parity build.
module tb_uart_rx;
  import npu_uart_pkg::*;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if u_if();

  uart_rx #(.CLKS_PER_BIT(CPB)) u_dut (
    .clk (clk),
    .rst (rst),
    .rx  (u_if.slave)
  );

  int errs = 0, checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame-level model: bytes that must appear, in order, plus error tallies.
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int exp_ferr = 0, exp_perr = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0;
  int last_valid_cyc = 0, start_cyc = 0;

  logic pv = 1'b0, pf = 1'b0, pp = 1'b0;
  always @(negedge clk) begin
    logic v, f, p;
    v = u_if.rx_valid;
    f = u_if.frame_err;
`ifdef UART_RX_PARITY_EN
    p = u_if.parity_err;
`else
    p = 1'b0;
`endif
    if (v) begin
      n_valid++;
      last_valid_cyc = cyc;
      chk("valid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("rx_data", 32'(u_if.rx_data), 32'(exp_q.pop_front()));
    end
    if (f) n_ferr++;
    if (p) n_perr++;
    if (v | f | p) begin
      chk("pulse_excl", 32'(int'(v) + int'(f) + int'(p)), 32'd1);
      chk("pulse_single", 32'({pv, pf, pp} & {v, f, p}), 32'd0);
    end
    pv = v; pf = f; pp = p;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    u_if.rx_serial = 1'b1;
    step(n);
  endtask

  // rst_at >= 0 pulses rst for one cycle at that offset into the frame.
  task automatic send(input logic [7:0] b, input bit bad_stop, input bit bad_par, input int rst_at);
    logic [10:0] bits;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
    bits[9]   = (^b) ^ bad_par;
    bits[10]  = ~bad_stop;
`else
    bits[9]   = ~bad_stop;
`endif
    if (rst_at < 0) begin
      if (bad_stop) exp_ferr++;
`ifdef UART_RX_PARITY_EN
      else if (bad_par) exp_perr++;
`endif
      else begin
        exp_q.push_back(b);
        last_good = b;
      end
    end
    start_cyc = cyc;
    for (int i = 0; i < NB; i++) begin
      for (int c = 0; c < CPB; c++) begin
        u_if.rx_serial = bits[i];
        rst = (rst_at >= 0) && (i*CPB + c == rst_at);
        step(1);
      end
    end
    rst = 1'b0;
    if (rst_at >= 0) last_good = 8'h00;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0, p0, e0, lat, w, n_exp;
    logic [7:0] b;
    bit bs, bp;

    u_if.rx_serial = 1'b1;
    rst = 1'b1;
    step(4);
    chk("rst_rx_data", 32'(u_if.rx_data), 32'h00);
    chk("rst_rx_valid", 32'(u_if.rx_valid), 32'd0);
    chk("rst_frame_err", 32'(u_if.frame_err), 32'd0);
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    rst = 1'b0;
    idle(5);

    // Single frame and latency from the start edge.
    v0 = n_valid;
    send(8'hA5, 0, 0, -1);
    idle(20);
    chk("a5_count", 32'(n_valid - v0), 32'd1);
    chk("a5_data", 32'(u_if.rx_data), 32'hA5);
    lat = last_valid_cyc - start_cyc;
    chk("a5_latency", 32'(lat >= NB*CPB - CPB/2 + 1 && lat <= NB*CPB - CPB/2 + 3), 32'd1);

    // Back-to-back frames.
    v0 = n_valid; f0 = n_ferr;
    for (int i = 0; i < 32; i++) send(8'(i), 0, 0, -1);
    idle(20);
    chk("b2b_count", 32'(n_valid - v0), 32'd32);
    chk("b2b_pending", 32'(exp_q.size()), 32'd0);
    chk("b2b_ferr", 32'(n_ferr - f0), 32'd0);

    // Stop bit low followed by a break.
    v0 = n_valid; f0 = n_ferr;
    send(8'h3C, 1, 0, -1);
    u_if.rx_serial = 1'b0;
    step(40);
    idle(10);
    chk("brk_ferr", 32'(n_ferr - f0), 32'd1);
    chk("brk_valid", 32'(n_valid - v0), 32'd0);
    chk("brk_hold", 32'(u_if.rx_data), 32'(last_good));
    send(8'h7E, 0, 0, -1);
    idle(20);
    chk("after_brk_valid", 32'(n_valid - v0), 32'd1);
    chk("after_brk_data", 32'(u_if.rx_data), 32'h7E);

    // Short glitch is a false start.
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    u_if.rx_serial = 1'b0;
    step(4);
    u_if.rx_serial = 1'b1;
    chk("glitch_busy_seen", 32'(u_if.busy), 32'd1);
    w = 0;
    while (u_if.busy && w < 12) begin
      step(1);
      w++;
    end
    chk("glitch_busy_low", 32'(u_if.busy), 32'd0);
    idle(20);
    chk("glitch_pulses", 32'((n_valid - v0) + (n_ferr - f0) + (n_perr - p0)), 32'd0);

    // Reset during data bit 4.
    v0 = n_valid; f0 = n_ferr;
    send(8'hFF, 0, 0, 5*CPB + CPB/2);
    idle(10);
    chk("rst_abort_pulses", 32'((n_valid - v0) + (n_ferr - f0)), 32'd0);
    chk("rst_abort_data", 32'(u_if.rx_data), 32'h00);
    send(8'h12, 0, 0, -1);
    idle(20);
    chk("post_rst_valid", 32'(n_valid - v0), 32'd1);
    chk("post_rst_data", 32'(u_if.rx_data), 32'h12);

    // Random bytes, gaps and framing/parity errors.
    v0 = n_valid; e0 = exp_ferr; f0 = n_ferr; n_exp = 0;
    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom);
      bs = ($urandom_range(0, 5) == 0);
`ifdef UART_RX_PARITY_EN
      bp = ($urandom_range(0, 4) == 0);
`else
      bp = 1'b0;
`endif
      if (!bs && !bp) n_exp++;
      send(b, bs, bp, -1);
      idle(bs ? CPB + $urandom_range(0, 8) : $urandom_range(0, 8));
    end
    idle(20);
    chk("rand_valid", 32'(n_valid - v0), 32'(n_exp));
    chk("rand_ferr", 32'(n_ferr - f0), 32'(exp_ferr - e0));
    chk("rand_pending", 32'(exp_q.size()), 32'd0);
    chk("rand_hold", 32'(u_if.rx_data), 32'(last_good));

`ifdef UART_RX_PARITY_EN
    v0 = n_valid; p0 = n_perr;
    send(8'h81, 0, 1, -1);
    idle(20);
    chk("par_bad_perr", 32'(n_perr - p0), 32'd1);
    chk("par_bad_valid", 32'(n_valid - v0), 32'd0);
    send(8'h81, 0, 0, -1);
    idle(20);
    chk("par_ok_valid", 32'(n_valid - v0), 32'd1);
    chk("par_ok_data", 32'(u_if.rx_data), 32'h81);
    chk("perr_total", 32'(n_perr), 32'(exp_perr));
`endif

    chk("ferr_total", 32'(n_ferr), 32'(exp_ferr));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
